// File: rtl/state8_pkg.sv
// Shared constants, sequencer state encoding and one-hot helper for the
// 8-state SR-latch pulse encoder.
package state8_pkg;

    localparam int STATE_W = 3;
    localparam int NSTATE  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PULSE  = 2'd1,
        SETTLE = 2'd2,
        CHECK  = 2'd3
    } seq_state_e;

    function automatic logic [NSTATE-1:0] onehot8(input logic [STATE_W-1:0] code);
        return NSTATE'(1) << code;
    endfunction

endpackage

// File: rtl/state8_pulse_encoder_sync2.sv
// Two-flop synchronizer used to bring the asynchronous latch feedback
// into the clk domain.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         porb,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or negedge porb) begin
        if (!porb) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/state8_pulse_encoder.sv
// Sequencer that drives set/reset pulses into the 8-state SR-latch register,
// waits for the feedback to settle, confirms the target and retries on a miss.
module state8_pulse_encoder
    import state8_pkg::*;
#(
    parameter int PULSE_W   = 2,
    parameter int SETTLE    = 3,
    parameter int MAX_RETRY = 2
) (
    input  logic               clk,
    input  logic               porb,
    input  logic               goto_valid,
    input  logic [STATE_W-1:0] goto_state,
    output logic               goto_ready,
    input  logic [NSTATE-1:0]  state_fb,
    output logic [STATE_W-1:0] s,
    output logic [STATE_W-1:0] r,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int CMAX = (PULSE_W > SETTLE) ? PULSE_W : SETTLE;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int RW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    seq_state_e         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [RW-1:0]      retry_q, retry_d;
    logic [STATE_W-1:0] tgt_q, tgt_d;
    logic [STATE_W-1:0] cur_q, cur_d;
    logic               known_q, known_d;
    logic [STATE_W-1:0] smask_q, smask_d;
    logic [STATE_W-1:0] rmask_q, rmask_d;
    logic               match_q, match_d;
    logic [STATE_W-1:0] s_q, s_d;
    logic [STATE_W-1:0] r_q, r_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic               ready_q, ready_d;
    logic [NSTATE-1:0]  fb_sync;

    sync2 #(.W(NSTATE)) u_fb_sync (
        .clk  (clk),
        .porb (porb),
        .d    (state_fb),
        .q    (fb_sync)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        tgt_d   = tgt_q;
        cur_d   = cur_q;
        known_d = known_q;
        smask_d = smask_q;
        rmask_d = rmask_q;
        match_d = match_q;
        err_d   = err_q;
        done_d  = 1'b0;

        case (state_q)
            state8_pkg::IDLE: begin
                if (goto_valid) begin
                    tgt_d   = goto_state;
                    err_d   = 1'b0;
                    retry_d = '0;
                    // Only touch bits that differ when the shadow is trusted.
                    if (known_q) begin
                        smask_d = goto_state & ~cur_q;
                        rmask_d = ~goto_state & cur_q;
                    end else begin
                        smask_d = goto_state;
                        rmask_d = ~goto_state;
                    end
                    if ((smask_d | rmask_d) != '0) begin
                        state_d = state8_pkg::PULSE;
                        cnt_d   = CW'(PULSE_W - 1);
                    end else begin
                        state_d = state8_pkg::SETTLE;
                        cnt_d   = CW'(SETTLE - 1);
                    end
                end
            end
            state8_pkg::PULSE: begin
                if (cnt_q == '0) begin
                    state_d = state8_pkg::SETTLE;
                    cnt_d   = CW'(SETTLE - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            state8_pkg::SETTLE: begin
                if (cnt_q == '0) begin
                    // Decide here so that done is a registered pulse during CHECK.
                    state_d = state8_pkg::CHECK;
                    match_d = (fb_sync == onehot8(tgt_q));
                    done_d  = match_d;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            state8_pkg::CHECK: begin
                if (match_q) begin
                    cur_d   = tgt_q;
                    known_d = 1'b1;
                    state_d = state8_pkg::IDLE;
                end else if (retry_q < RW'(MAX_RETRY)) begin
                    retry_d = retry_q + 1'b1;
                    smask_d = tgt_q;
                    rmask_d = ~tgt_q;
                    state_d = state8_pkg::PULSE;
                    cnt_d   = CW'(PULSE_W - 1);
                end else begin
                    err_d   = 1'b1;
                    known_d = 1'b0;
                    state_d = state8_pkg::IDLE;
                end
            end
            default: state_d = state8_pkg::IDLE;
        endcase

        s_d     = (state_d == state8_pkg::PULSE) ? smask_d : '0;
        r_d     = (state_d == state8_pkg::PULSE) ? rmask_d : '0;
        busy_d  = (state_d != state8_pkg::IDLE);
        ready_d = (state_d == state8_pkg::IDLE);
    end

    always_ff @(posedge clk or negedge porb) begin
        if (!porb) begin
            state_q <= state8_pkg::IDLE;
            cnt_q   <= '0;
            retry_q <= '0;
            tgt_q   <= '0;
            cur_q   <= '0;
            known_q <= 1'b1;
            smask_q <= '0;
            rmask_q <= '0;
            match_q <= 1'b0;
            s_q     <= '0;
            r_q     <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            tgt_q   <= tgt_d;
            cur_q   <= cur_d;
            known_q <= known_d;
            smask_q <= smask_d;
            rmask_q <= rmask_d;
            match_q <= match_d;
            s_q     <= s_d;
            r_q     <= r_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    assign s          = s_q;
    assign r          = r_q;
    assign done       = done_q;
    assign err        = err_q;
    assign busy       = busy_q;
    assign goto_ready = ready_q;

    // A latch bit must never see set and reset asserted together.
    a_no_sr_overlap: assert property (@(posedge clk) disable iff (!porb) (s_q & r_q) == '0);

endmodule

// File: tb/tb_state8_pulse_encoder.sv
// Randomized bench for state8_pulse_encoder with an SR-latch plant and a
// transaction-level predictor of pulses, done/err and latency.
module tb_state8_pulse_encoder;

    localparam int PW = 2;
    localparam int ST = 3;
    localparam int MR = 2;

    logic       clk = 1'b0;
    logic       porb = 1'b0;
    logic       goto_valid = 1'b0;
    logic [2:0] goto_state = 3'd0;
    logic       goto_ready;
    logic [7:0] state_fb;
    logic [2:0] s, r;
    logic       busy, done, err;

    int n_checks = 0;
    int n_errors = 0;

    // Plant: SR latch bank with optional stuck-at-0 bits, cleared by porb.
    logic [2:0] latch_q;
    logic [2:0] stuck = 3'd0;

    // Predictor state.
    logic [2:0] m_cur = 3'd0;
    bit         m_known = 1'b1;
    logic [2:0] m_latch = 3'd0;

    state8_pulse_encoder #(.PULSE_W(PW), .SETTLE(ST), .MAX_RETRY(MR)) dut (
        .clk        (clk),
        .porb       (porb),
        .goto_valid (goto_valid),
        .goto_state (goto_state),
        .goto_ready (goto_ready),
        .state_fb   (state_fb),
        .s          (s),
        .r          (r),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk or negedge porb) begin
        if (!porb) latch_q <= 3'd0;
        else       latch_q <= ((latch_q | s) & ~r) & ~stuck;
    end

    assign state_fb = 8'd1 << latch_q;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] pk(input bit b, input bit rdy, input bit d, input bit e,
                                      input logic [2:0] sv, input logic [2:0] rv);
        return {b, rdy, d, e, sv, rv};
    endfunction

    // Predict the whole transaction, then drive it and compare every cycle.
    task automatic run_req(input logic [2:0] code, input int inj, input logic [2:0] inj_code);
        logic [9:0] expv [0:63];
        logic [2:0] sm, rm;
        int base, chk_at, retry, inj_at;
        bit ok;
        for (int i = 0; i < 64; i++) expv[i] = pk(1, 0, 0, 0, 3'd0, 3'd0);
        if (m_known) begin
            sm = code & ~m_cur;
            rm = ~code & m_cur;
        end else begin
            sm = code;
            rm = ~code;
        end
        base = 0;
        retry = 0;
        ok = 1'b0;
        chk_at = 0;
        while (1) begin
            if ((sm | rm) != 3'd0) begin
                for (int o = base + 1; o <= base + PW; o++) expv[o] = pk(1, 0, 0, 0, sm, rm);
                m_latch = ((m_latch | sm) & ~rm) & ~stuck;
                chk_at = base + PW + ST + 1;
            end else begin
                chk_at = base + ST + 1;
            end
            ok = (m_latch == code);
            if (ok || retry == MR) break;
            retry++;
            base = chk_at;
            sm = code;
            rm = ~code;
        end
        expv[chk_at]     = pk(1, 0, ok, 0, 3'd0, 3'd0);
        expv[chk_at + 1] = pk(0, 1, 0, !ok, 3'd0, 3'd0);
        if (ok) begin
            m_cur = code;
            m_known = 1'b1;
        end else begin
            m_known = 1'b0;
        end
        inj_at = (inj >= chk_at) ? 0 : inj;

        @(negedge clk);
        check_val("ready_before_req", 32'(goto_ready), 32'd1);
        goto_valid = 1'b1;
        goto_state = code;
        @(posedge clk);
        #1 goto_valid = 1'b0;
        for (int o = 1; o <= chk_at + 1; o++) begin
            @(negedge clk);
            check_val($sformatf("req%0d_t%0d", code, o),
                      32'(pk(busy, goto_ready, done, err, s, r)), 32'(expv[o]));
            if (inj_at != 0 && o == inj_at) begin
                goto_valid = 1'b1;
                goto_state = inj_code;
            end else if (inj_at != 0 && o == inj_at + 1) begin
                goto_valid = 1'b0;
            end
        end
        $display("req code=%0d stuck=%b retries=%0d latency=%0d ok=%0b inject=%0d",
                 code, stuck, retry, chk_at, ok, inj_at);
    endtask

    task automatic reset_mid_pulse(input logic [2:0] code);
        logic [2:0] sm, rm;
        sm = m_known ? (code & ~m_cur) : code;
        rm = m_known ? (~code & m_cur) : ~code;
        @(negedge clk);
        goto_valid = 1'b1;
        goto_state = code;
        @(posedge clk);
        #1 goto_valid = 1'b0;
        @(negedge clk);
        check_val("midrst_pulse_on", 32'({s, r}), 32'({sm, rm}));
        #1 porb = 1'b0;
        #1;
        check_val("midrst_sr_async", 32'({s, r}), 32'd0);
        check_val("midrst_busy_async", 32'(busy), 32'd0);
        @(negedge clk);
        porb = 1'b1;
        m_cur = 3'd0;
        m_known = 1'b1;
        m_latch = 3'd0;
        @(negedge clk);
        check_val("midrst_after", 32'({busy, goto_ready, done, err, s, r}), 32'(pk(0, 1, 0, 0, 3'd0, 3'd0)));
        $display("reset during pulse code=%0d", code);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_val("rst_outputs", 32'({busy, goto_ready, done, err, s, r}), 32'(pk(0, 1, 0, 0, 3'd0, 3'd0)));
        porb = 1'b1;
        @(negedge clk);
        check_val("rst_release", 32'({busy, goto_ready, done, err, s, r}), 32'(pk(0, 1, 0, 0, 3'd0, 3'd0)));

        run_req(3'd5, 0, 3'd0);
        run_req(3'd2, 0, 3'd0);
        run_req(3'd2, 0, 3'd0);
        stuck = 3'b010;
        m_latch = m_latch & ~stuck;
        run_req(3'd6, 0, 3'd0);
        stuck = 3'b000;
        run_req(3'd0, 0, 3'd0);
        run_req(3'd1, 0, 3'd0);
        reset_mid_pulse(3'd6);
        run_req(3'd3, PW + 2, 3'd6);

        for (int k = 0; k < 40; k++) begin
            logic [2:0] code, icode;
            int inj;
            stuck = ($urandom_range(0, 7) == 0) ? 3'(1 << $urandom_range(0, 2)) : 3'd0;
            m_latch = m_latch & ~stuck;
            code = 3'($urandom_range(0, 7));
            icode = 3'($urandom_range(0, 7));
            inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 8)) : 0;
            run_req(code, inj, icode);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/state8_pulse_encoder.md
# state8_pulse_encoder

Synchronous sequencer that drives the set/reset pulse inputs of the 8-state SR-latch state register in the loop control path. It accepts a 3-bit target-state request and computes the per-bit set/reset pulses from a shadow copy of the latched code. It fires those pulses, lets them settle, then confirms the transition against the register's decoded one-hot `state[7:0]` feedback. It retries on mismatch and flags an error if the register never reaches the target.

## Interface
Parameters:
- `PULSE_W`, default 2: width of each set/reset pulse in clock cycles; must be ≥1.
- `SETTLE`, default 3: idle cycles between pulse end and the feedback check; must be ≥2, because it covers the feedback synchronizer.
- `MAX_RETRY`, default 2: number of full-drive retries before `err`.

Ports:
- `clk` in 1: single clock; every flop is on its rising edge.
- `porb` in 1: asynchronous, active-low reset. Deasserted synchronously, outside this block.
- `goto_valid` in 1: a target request is present.
- `goto_state` in 3: target code, 0–7.
- `goto_ready` out 1: high only in IDLE.
- `state_fb` in 8: one-hot decoded state from the latch register; asynchronous to `clk`.
- `s` out 3: set pulses, bit n drives latch n.
- `r` out 3: reset pulses, bit n drives latch n.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `done` out 1: one-cycle pulse when the transition is confirmed.
- `err` out 1: sticky; cleared when the next request is accepted.

## Operation
- The FSM has four states: IDLE, PULSE, SETTLE, CHECK.
- **Shadow register:** `cur[2:0]` plus a `known` flag. Reset value is `cur=0`, `known=1`, matching the latch register being cleared by the same `porb`.
- **Accept:** a request is accepted when `goto_valid & goto_ready`. The block latches `tgt = goto_state`, clears `err`, and zeroes the retry counter.
- **Pulse masks for a normal request** (`known=1`):
  - `smask = tgt & ~cur`
  - `rmask = ~tgt & cur`
- **Pulse masks for full-drive** (`known=0`, or a retry):
  - `smask = tgt`
  - `rmask = ~tgt`
- Bit n never has `s[n]` and `r[n]` high together. This holds by construction and carries an assertion.
- **Transitions:**
  - IDLE → PULSE on accept if `smask|rmask != 0`.
  - IDLE → SETTLE on accept if both masks are zero.
  - PULSE holds `s=smask`, `r=rmask` for exactly `PULSE_W` cycles, then goes to SETTLE.
  - SETTLE lasts `SETTLE` cycles, then goes to CHECK.
  - CHECK lasts one cycle. It compares the synchronized feedback against `(8'b1 << tgt)`, exact equality, so any other pattern is a miss.
- **CHECK match:** `done=1`, `cur=tgt`, `known=1`, → IDLE.
- **CHECK miss with retries left:** increment the retry counter, use full-drive masks, → PULSE.
- **CHECK miss with retries exhausted:** `err=1`, `known=0`, → IDLE, no `done`. The next request therefore full-drives.
- `goto_valid` is ignored while `busy`. No request is queued.

## Timing
- **Reset values:** `s=0`, `r=0`, `goto_ready=1`, `busy=0`, `done=0`, `err=0`, FSM=IDLE, `cur=0`, `known=1`, retry counter 0, synchronizer flops 0.
- All outputs are registered; there is no combinational input-to-output path.
- **Changing request accepted at cycle T** (defaults):
  - `s`/`r` high T+1..T+PULSE_W (T+1..T+2).
  - SETTLE T+3..T+5.
  - CHECK T+6; `done` high at T+6.
  - `goto_ready` returns at T+7.
- **Same-state request accepted at T:** SETTLE T+1..T+SETTLE, `done` at T+SETTLE+1 (T+4).
- Each retry adds `PULSE_W+SETTLE+1` cycles.
- **Feedback path:** `state_fb` passes through a 2-flop synchronizer, so CHECK sees samples at least 2 cycles old. `SETTLE≥2` guarantees those samples postdate the pulse.
- **`porb` low at any time:** `s`/`r` drop asynchronously and immediately, the FSM returns to IDLE, `err` clears, and the shadow resets to `cur=0`, `known=1`. An in-flight request is discarded with no `done`.

## Structure
- **Package `state8_pkg`:**
  - constants `STATE_W=3`, `NSTATE=8`;
  - enum `seq_state_e {IDLE, PULSE, SETTLE, CHECK}`;
  - function `onehot8(code)`.
- **Sub-module `sync2`:** parameterized-width two-flop synchronizer with async active-low reset, instantiated at width 8 on `state_fb`.
- **Counters:** pulse/settle counter width is `$clog2(max(PULSE_W,SETTLE)+1)`; retry counter width is `$clog2(MAX_RETRY+1)`.

## Test plan
- **Reset, request 5, model follows:** after `porb` release, request 5 with an ideal latch model. Expect `s=3'b101`, `r=0` for T+1..T+2, `done` at T+6, `cur=5`.
- **Back-to-back 5 → 2:** from state 5, request 2. Expect `s=3'b010`, `r=3'b101`, never both on one bit, `done` at T+6.
- **Same-state request:** request 2 while in 2. Expect no pulses, `done` at T+4.
- **Stuck bit 1 at 0:** request 6 with bit 1 stuck. Expect 2 full-drive retries with `s=3'b110`, `r=3'b001` each, then `err=1`, no `done`. The next request 0 then drives `r=3'b111`.
- **Reset mid-operation:** assert `porb` low during PULSE. Expect `s`/`r` to fall within the same cycle, and `busy=0`, `goto_ready=1` after release.
- **Request while busy:** pulse `goto_valid` with a different code during SETTLE. Expect it ignored, the original target completed, and `done` once.
